// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter between the execution units (index 0 = MEM)
// and the two ALU write ports of the physical register file. Each requester
// owns a small FIFO; up to two eligible heads are granted per cycle by
// round-robin, and the chosen results are driven out through registered
// write strobes with a matching wakeup tag (wdest).
// Optional build macro: WBARB_MEMPRIO_EN gives MEM a fixed claim on port 0
// whenever its head is eligible; the other port stays round-robin over 1..NREQ-1.
module wb_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 3,
  parameter int DEPTH     = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req_valid,
  input  logic [NREQ*WIDTH_REG-1:0] i_req_addr,
  input  logic [NREQ*32-1:0]        i_req_data,
  input  logic [NREQ*WIDTH_BRM-1:0] i_req_brmask,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic                      i_kill_en,
  input  logic [WIDTH_BRM-1:0]      i_kill_mask,
  output logic [1:0]                o_we,
  output logic [2*WIDTH_REG-1:0]    o_waddr,
  output logic [2*32-1:0]           o_wdata,
  output logic [2*WIDTH_REG-1:0]    o_wdest
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]       r_rr;
  logic [RRW-1:0]       w_rrNext;
  logic [NREQ-1:0]      w_ready;
  logic [NREQ-1:0]      w_push;
  logic [NREQ-1:0]      w_pop;
  logic [NREQ-1:0]      w_elig;
  logic [NREQ-1:0]      w_grant;
  logic [1:0]           w_portVld;
  logic [RRW-1:0]       w_portIdx  [2];
  logic [WIDTH_REG-1:0] w_headAddr [NREQ];
  logic [31:0]          w_headData [NREQ];

  // A branch mask is hit when the kill strobe is up and any of its bits is being killed
  function automatic logic hits(input logic [WIDTH_BRM-1:0] mask);
    return i_kill_en && (|(mask & i_kill_mask));
  endfunction

  // Ready is withheld during reset so nothing is accepted into FIFOs that are being cleared
  assign o_req_ready = w_ready & ~{NREQ{i_rst}};

  for (genvar r = 0; r < NREQ; r++) begin : g_fifo
    logic [DEPTH-1:0]     r_vld;
    logic [WIDTH_REG-1:0] r_addr [DEPTH];
    logic [31:0]          r_data [DEPTH];
    logic [WIDTH_BRM-1:0] r_brm  [DEPTH];
    logic [PW-1:0]        r_rdPtr;
    logic [PW-1:0]        r_wrPtr;
    logic [CW-1:0]        r_count;
    logic [DEPTH-1:0]     w_killVec;
    logic [DEPTH-1:0]     w_wrSel;
    logic                 w_inVld;
    logic                 w_nonEmpty;

    for (genvar d = 0; d < DEPTH; d++) begin : g_ent
      assign w_killVec[d] = hits(r_brm[d]);
      assign w_wrSel[d]   = w_push[r] && (r_wrPtr == PW'(d));
    end

    assign w_inVld       = !hits(i_req_brmask[r*WIDTH_BRM +: WIDTH_BRM]);
    assign w_nonEmpty    = (r_count != '0);
    assign w_ready[r]    = (r_count < CW'(DEPTH));
    assign w_push[r]     = i_req_valid[r] && o_req_ready[r];
    assign w_headAddr[r] = r_addr[r_rdPtr];
    assign w_headData[r] = r_data[r_rdPtr];
    assign w_elig[r]     = w_nonEmpty && r_vld[r_rdPtr] && (w_headAddr[r] != '0)
                           && !hits(r_brm[r_rdPtr]);
    // Ineligible heads (x0 destination or killed) are discarded without using a port
    assign w_pop[r]      = w_nonEmpty && (w_grant[r] || !w_elig[r]);

    // FIFO storage: kills invalidate matching entries, push fills the tail, pop advances the head
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld   <= '0;
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        r_vld <= (r_vld & ~w_killVec & ~w_wrSel) | (w_wrSel & {DEPTH{w_inVld}});
        if (w_push[r]) begin
          r_addr[r_wrPtr] <= i_req_addr[r*WIDTH_REG +: WIDTH_REG];
          r_data[r_wrPtr] <= i_req_data[r*32 +: 32];
          r_brm[r_wrPtr]  <= i_req_brmask[r*WIDTH_BRM +: WIDTH_BRM];
          r_wrPtr         <= r_wrPtr + 1'b1;
        end
        if (w_pop[r]) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        if (w_push[r] && !w_pop[r]) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push[r] && w_pop[r]) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  // Cyclic scan from rr: first eligible head takes port 0, second takes port 1
  always_comb begin
    int             idx;
    logic [RRW-1:0] idxS;
    logic [1:0]     nGnt;
    logic           skip;
    w_grant      = '0;
    w_portVld    = '0;
    w_portIdx[0] = '0;
    w_portIdx[1] = '0;
    w_rrNext     = r_rr;
    nGnt         = 2'd0;
    idx          = 0;
    idxS         = '0;
    skip         = 1'b0;
`ifdef WBARB_MEMPRIO_EN
    if (w_elig[0]) begin
      w_grant[0]   = 1'b1;
      w_portVld[0] = 1'b1;
      nGnt         = 2'd1;
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idxS = RRW'(idx);
`ifdef WBARB_MEMPRIO_EN
      skip = (idx == 0);
`endif
      if (!skip && w_elig[idxS] && (nGnt < 2'd2)) begin
        w_grant[idxS]         = 1'b1;
        w_portVld[nGnt[0]]    = 1'b1;
        w_portIdx[nGnt[0]]    = idxS;
        w_rrNext              = (idx == NREQ - 1) ? '0 : RRW'(idx + 1);
        nGnt                  = nGnt + 2'd1;
      end
    end
  end

  // Round-robin pointer moves past the last granted requester; idle cycles leave it alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= '0;
    end else begin
      r_rr <= w_rrNext;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                 r_we;
    logic [WIDTH_REG-1:0] r_waddr;
    logic [31:0]          r_wdata;
    logic [WIDTH_REG-1:0] r_wdest;

    // Registered write port: idle ports drop the strobe and tag but hold address and data
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_we    <= 1'b0;
        r_waddr <= '0;
        r_wdata <= '0;
        r_wdest <= '0;
      end else if (w_portVld[p]) begin
        r_we    <= 1'b1;
        r_waddr <= w_headAddr[w_portIdx[p]];
        r_wdata <= w_headData[w_portIdx[p]];
        r_wdest <= w_headAddr[w_portIdx[p]];
      end else begin
        r_we    <= 1'b0;
        r_wdest <= '0;
      end
    end

    assign o_we[p]                            = r_we;
    assign o_waddr[p*WIDTH_REG +: WIDTH_REG]  = r_waddr;
    assign o_wdata[p*32 +: 32]                = r_wdata;
    assign o_wdest[p*WIDTH_REG +: WIDTH_REG]  = r_wdest;
  end

endmodule
